spike_rate_decoder: RTL
=======================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter N_CH, default 8: number of spike channels.
REQ-002 Parameter WIN_LOG2, default 4, legal 1..8: window length is 2^WIN_LOG2 valid samples.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset: asynchronous, active-low.
REQ-005 enable  input  1  high: accumulate; low: idle, counters held at zero.
REQ-006 spike_in  input  N_CH  one spike bit per channel, sampled when spike_valid=1.
REQ-007 spike_valid  input  1  spike_in sample strobe.
REQ-008 rate_valid  output  1  rate_out/rate_ch hold a valid result.
REQ-009 rate_ready  input  1  consumer accepts result when rate_valid&&rate_ready.
REQ-010 rate_out  output  8  scaled spike rate of channel rate_ch.
REQ-011 rate_ch  output  3  channel index of rate_out (ceil(log2 N_CH) bits).
REQ-012 window_done  output  1  one-cycle pulse on the cycle after a window closes.
REQ-013 overrun  output  1  sticky: a window result was dropped.

Function
REQ-014 FSM states: IDLE (enable=0), ACCUM (counting, no results pending), DRAIN (results streaming; counting continues).
REQ-015 IDLE->ACCUM when enable=1. ACCUM->DRAIN when a window closes. DRAIN->ACCUM after the last channel handshake. Any state->IDLE when enable=0: counters cleared, pending results discarded, rate_valid=0.
REQ-016 Each cycle with spike_valid=1 in ACCUM/DRAIN: count[i] += spike_in[i]; sample counter += 1.
REQ-017 Counter width WIN_LOG2+1 bits; max count 2^WIN_LOG2, no wrap.
REQ-018 The window closes on the valid sample that brings the sample counter to 2^WIN_LOG2. That sample is included; on the same edge counts are copied to a shadow buffer, and counters and sample counter go to 0.
REQ-019 Scaling: rate = count << (8-WIN_LOG2), saturated to 255. Example: count=2^WIN_LOG2 gives 255.
REQ-020 DRAIN presents channels 0..N_CH-1 in order.
REQ-021 rate_valid rises the cycle after the window closes.
REQ-022 rate_out and rate_ch stay stable while rate_valid=1 and rate_ready=0.
REQ-023 On a handshake, the next channel appears the following cycle, giving one result per cycle under constant ready.
REQ-024 rate_valid drops after the channel N_CH-1 handshake.
REQ-025 A window closing while in DRAIN: overrun set, new snapshot dropped, shadow buffer and output unchanged, counters still clear and counting continues.
REQ-026 Window closing on the same cycle as the final handshake: this is not an overrun. The new snapshot is loaded and DRAIN restarts at channel 0 the next cycle.
REQ-027 overrun clears only on reset or when enable=0.
REQ-028 spike_valid=0 cycles do not advance any counter.

Reset
REQ-029 rst_n=0 asynchronously forces IDLE and clears all counters and the shadow buffer.
REQ-030 Output reset values: rate_valid=0, rate_out=0, rate_ch=0, window_done=0, overrun=0.
REQ-031 Reset mid-DRAIN discards pending results; no partial stream resumes after release.
REQ-032 First accumulation begins on the first clk edge with rst_n=1 and enable=1.

Structure
REQ-033 Shared package snn_pkg holds the N_CH default, the rate width (8), the FSM state enum (IDLE/ACCUM/DRAIN) and the saturating scale function.
REQ-034 One sub-module, spike_counter, implements the per-channel (WIN_LOG2+1)-bit counter with increment and synchronous clear; it is instantiated N_CH times.

Verification
REQ-035 WIN_LOG2=4, spike_in=8'hFF, 16 consecutive valid samples, rate_ready=1 -> window_done pulse, then 8 results ch0..7 on consecutive cycles, each rate_out=255.
REQ-036 ch0 toggles 1/0 over 16 valid samples, others 0 -> ch0 rate_out=128 (8<<4), ch1..7 rate_out=0.
REQ-037 spike_valid high every other cycle, spike_in=8'h01 -> window closes after 32 cycles, ch0=255; invalid cycles are not counted.
REQ-038 rate_ready=0 throughout 2 windows -> ch0 result held stable, overrun=1 at second close; after release the first window's values are drained unchanged.
REQ-039 rst_n pulsed low mid-DRAIN at ch3 -> all outputs 0 immediately; after release no results until a fresh 16-sample window completes.
REQ-040 Last handshake coincident with the next window close -> overrun stays 0, and ch0 of the new window appears the next cycle.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spike-rate decoding datapath.
// Holds the channel default, rate width, FSM states and rate scaling.
package snn_pkg;

    localparam int N_CH_DEF = 8;
    localparam int RATE_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Count is at most 2^8, so nine bits always hold it.
    function automatic logic [RATE_W-1:0] sat_scale(
        input logic [8:0] cnt,
        input int         win_log2
    );
        logic [16:0] w;
        w = {8'd0, cnt} << (RATE_W - win_log2);
        if (w > 17'd255) begin
            return '1;
        end
        return w[RATE_W-1:0];
    endfunction

endpackage

// File: rtl/spike_counter.sv
// Per-channel spike counter: increments on inc, synchronous clear.
// Holds at its maximum value instead of wrapping.
module spike_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = {1'b1, {(W-1){1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: counts spikes per channel over a window
// of valid samples, then streams scaled rates channel by channel.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int WIN_LOG2 = 4,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_CH-1:0]   spike_in,
    input  logic              spike_valid,
    output logic              rate_valid,
    input  logic              rate_ready,
    output logic [RATE_W-1:0] rate_out,
    output logic [CH_W-1:0]   rate_ch,
    output logic              window_done,
    output logic              overrun
);

    localparam int CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] LAST_SMP = CW'((1 << WIN_LOG2) - 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt    [N_CH];
    logic [CW-1:0]   shadow [N_CH];
    logic [CW-1:0]   smp;
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] idx_n;
    logic            ovr_n;
    logic            load;
    logic            acc;
    logic            close;
    logic            cnt_clr;
    logic            hs;
    logic            last;
    logic [8:0]      sel_ext;

    assign acc     = enable & spike_valid;
    assign close   = acc && (smp == LAST_SMP);
    assign cnt_clr = ~enable | close;
    assign hs      = (state == DRAIN) && rate_ready;
    assign last    = hs && (idx == LAST_CH);

    for (genvar i = 0; i < N_CH; i++) begin : g_cnt
        spike_counter #(
            .W(CW)
        ) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (cnt_clr),
            .inc  (acc & spike_in[i]),
            .count(cnt[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp <= '0;
        end else if (cnt_clr) begin
            smp <= '0;
        end else if (acc) begin
            smp <= smp + 1'b1;
        end
    end

    // A close coinciding with the final handshake reloads instead of overrunning.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        ovr_n   = overrun;
        load    = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            idx_n   = '0;
            ovr_n   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = ACCUM;
                end
                ACCUM: begin
                    if (close) begin
                        state_n = DRAIN;
                        idx_n   = '0;
                        load    = 1'b1;
                    end
                end
                DRAIN: begin
                    if (last) begin
                        idx_n = '0;
                        if (close) begin
                            load = 1'b1;
                        end else begin
                            state_n = ACCUM;
                        end
                    end else begin
                        if (hs) begin
                            idx_n = idx + 1'b1;
                        end
                        if (close) begin
                            ovr_n = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            overrun     <= 1'b0;
            window_done <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            overrun     <= ovr_n;
            window_done <= close;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= cnt[i] + {{(CW-1){1'b0}}, spike_in[i]};
            end
        end
    end

    always_comb begin
        sel_ext            = '0;
        sel_ext[CW-1:0]    = shadow[idx];
        rate_valid         = (state == DRAIN);
        rate_ch            = rate_valid ? idx : '0;
        rate_out           = rate_valid ? sat_scale(sel_ext, WIN_LOG2) : '0;
    end

endmodule
